// File: rtl/jbi_l2_req_out.sv
// jbi_l2_req_out
// ---------------
// JBI-side L2 request issue stage. Takes one complete request packet at a
// time (64-bit header, plus sixteen 32-bit data words for writes) and
// serialises it onto the 32-bit jbi_sctag_req bus. A valid strobe marks the
// first header beat, and each data beat carries a 7-bit ECC. L2 input-queue
// (IQ) and write-buffer (WIB) credits are tracked locally. A request is only
// accepted when the credits it needs are available.
//
// Handshake: a packet transfers in the cycle where req_valid && req_ready.
// req_ready already includes req_valid, so req_ready alone marks an accept.
// req_ready can only be high in IDLE with credit available. While req_ready
// is low, every upstream field may change freely.
//
// Optional feature (macro JBI_L2_REQ_ECC_GEN_EN):
//   defined   - jbi_scbuf_ecc comes from an internal 32-bit SEC-DED encoder
//               (zzecc_sctag_pgen_32b bit ordering); req_ecc is ignored.
//   undefined - jbi_scbuf_ecc is the req_ecc word that matches the beat.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    packet handshake
//   req_hdr, req_wr        header and write flag
//   req_data, req_ecc      write data (word i = req_data[511-32i -: 32]) and
//                          per-word ECC (word i = req_ecc[111-7i -: 7])
//   sctag_jbi_iq_dequeue   one IQ credit returned
//   sctag_jbi_wib_dequeue  one WIB credit returned
//   jbi_sctag_req          registered beat (header hi, header lo, data 0..15)
//   jbi_scbuf_ecc          registered ECC of the data beat, 0 on header beats
//   jbi_sctag_req_vld      high on the first header beat only
//   iq_credit, wib_credit  current credit counts
//   credit_err             sticky: a credit came back while already at max
module jbi_l2_req_out #(
  parameter int IQ_DEPTH  = 16,
  parameter int WIB_DEPTH = 4,
  localparam int IQ_W     = $clog2(IQ_DEPTH + 1),
  localparam int WIB_W    = $clog2(WIB_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_hdr,
  input  logic             req_wr,
  input  logic [511:0]     req_data,
  input  logic [111:0]     req_ecc,
  input  logic             sctag_jbi_iq_dequeue,
  input  logic             sctag_jbi_wib_dequeue,
  output logic [31:0]      jbi_sctag_req,
  output logic [6:0]       jbi_scbuf_ecc,
  output logic             jbi_sctag_req_vld,
  output logic [IQ_W-1:0]  iq_credit,
  output logic [WIB_W-1:0] wib_credit,
  output logic             credit_err
);

  localparam logic [IQ_W-1:0]  IQ_MAX  = IQ_W'(IQ_DEPTH);
  localparam logic [WIB_W-1:0] WIB_MAX = WIB_W'(WIB_DEPTH);

  // The state names what the output registers hold in this cycle.
  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

  state_t state, next_state;
  logic [3:0] beat, next_beat;

  // Holding register. It is loaded on accept. The upper header half goes
  // straight from req_hdr to the output flop on the accept edge, so only
  // the lower half needs to be kept.
  logic [31:0]       hold_hdr_lo;
  logic              hold_wr;
  logic [15:0][31:0] hold_data;   // word i lives at index 15-i
`ifndef JBI_L2_REQ_ECC_GEN_EN
  logic [15:0][6:0]  hold_ecc;    // word i lives at index 15-i
`endif

  logic        accept;
  logic        load_word;
  logic [3:0]  word_sel;
  logic [31:0] next_req;
  logic [6:0]  next_ecc;
  logic        next_vld;

`ifdef JBI_L2_REQ_ECC_GEN_EN
  // SEC-DED encoder. Data bit j takes the j-th non-power-of-two Hamming
  // position (3, 5, 6, 7, 9, ...). Check bit k is the XOR of the data bits
  // whose position has bit k set. Bit 6 is the overall parity of the data
  // and check bits.
  function automatic logic [6:0] ecc_gen(input logic [31:0] d);
    logic [5:0] p;
    logic [5:0] pos;
    logic [4:0] di;
    p  = '0;
    di = '0;
    for (int n = 3; n <= 38; n++) begin
      pos = 6'(n);
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        for (int k = 0; k < 6; k++) begin
          if (pos[k]) p[k] = p[k] ^ d[di];
        end
        di = di + 5'd1;
      end
    end
    return {(^d) ^ (^p), p};
  endfunction
`endif

  // Accept only from IDLE, only with the credits the packet needs, and
  // never while reset is asserted.
  assign req_ready = !rst && req_valid && (state == IDLE) &&
                     (iq_credit != '0) && (!req_wr || (wib_credit != '0));
  assign accept    = req_ready;

  // Next-state and next-output logic. The bus outputs are registered, so
  // this computes what the flops will hold in the following cycle.
  always_comb begin
    next_state = state;
    next_beat  = beat;
    load_word  = 1'b0;
    word_sel   = 4'd0;
    next_req   = '0;
    next_vld   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = HDR0;
          next_req   = req_hdr[63:32];
          next_vld   = 1'b1;
        end
      end
      HDR0: begin
        next_state = HDR1;
        next_req   = hold_hdr_lo;
      end
      HDR1: begin
        if (hold_wr) begin
          next_state = DATA;
          next_beat  = 4'd0;
          load_word  = 1'b1;
          word_sel   = 4'd0;
        end else begin
          next_state = IDLE;
        end
      end
      DATA: begin
        if (beat == 4'd15) begin
          next_state = IDLE;
        end else begin
          next_beat = beat + 4'd1;
          load_word = 1'b1;
          word_sel  = beat + 4'd1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (load_word) next_req = hold_data[4'd15 - word_sel];
  end

`ifdef JBI_L2_REQ_ECC_GEN_EN
  assign next_ecc = load_word ? ecc_gen(next_req) : 7'd0;
`else
  assign next_ecc = load_word ? hold_ecc[4'd15 - word_sel] : 7'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      beat              <= 4'd0;
      jbi_sctag_req     <= '0;
      jbi_scbuf_ecc     <= '0;
      jbi_sctag_req_vld <= 1'b0;
    end else begin
      state             <= next_state;
      beat              <= next_beat;
      jbi_sctag_req     <= next_req;
      jbi_scbuf_ecc     <= next_ecc;
      jbi_sctag_req_vld <= next_vld;
    end
  end

  // The holding register is only read after an accept has loaded it, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_hdr_lo <= req_hdr[31:0];
      hold_wr     <= req_wr;
      hold_data   <= req_data;
`ifndef JBI_L2_REQ_ECC_GEN_EN
      hold_ecc    <= req_ecc;
`endif
    end
  end

  // Credits. An accept and a return in the same cycle cancel out. A return
  // at max holds the count and raises the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      iq_credit  <= IQ_MAX;
      wib_credit <= WIB_MAX;
      credit_err <= 1'b0;
    end else begin
      if (sctag_jbi_iq_dequeue && !accept) begin
        if (iq_credit == IQ_MAX) credit_err <= 1'b1;
        else                     iq_credit  <= iq_credit + IQ_W'(1);
      end else if (!sctag_jbi_iq_dequeue && accept) begin
        iq_credit <= iq_credit - IQ_W'(1);
      end

      if (sctag_jbi_wib_dequeue && !(accept && req_wr)) begin
        if (wib_credit == WIB_MAX) credit_err <= 1'b1;
        else                       wib_credit <= wib_credit + WIB_W'(1);
      end else if (!sctag_jbi_wib_dequeue && accept && req_wr) begin
        wib_credit <= wib_credit - WIB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jbi_l2_req_out.sv
`timescale 1ns/1ps
module tb_jbi_l2_req_out;

  localparam int IQ_DEPTH  = 16;
  localparam int WIB_DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_hdr;
  logic         req_wr;
  logic [511:0] req_data;
  logic [111:0] req_ecc;
  logic         sctag_jbi_iq_dequeue;
  logic         sctag_jbi_wib_dequeue;
  logic [31:0]  jbi_sctag_req;
  logic [6:0]   jbi_scbuf_ecc;
  logic         jbi_sctag_req_vld;
  logic [4:0]   iq_credit;
  logic [2:0]   wib_credit;
  logic         credit_err;

  always #5 clk = ~clk;

  jbi_l2_req_out #(.IQ_DEPTH(IQ_DEPTH), .WIB_DEPTH(WIB_DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_hdr               (req_hdr),
    .req_wr                (req_wr),
    .req_data              (req_data),
    .req_ecc               (req_ecc),
    .sctag_jbi_iq_dequeue  (sctag_jbi_iq_dequeue),
    .sctag_jbi_wib_dequeue (sctag_jbi_wib_dequeue),
    .jbi_sctag_req         (jbi_sctag_req),
    .jbi_scbuf_ecc         (jbi_scbuf_ecc),
    .jbi_sctag_req_vld     (jbi_sctag_req_vld),
    .iq_credit             (iq_credit),
    .wib_credit            (wib_credit),
    .credit_err            (credit_err)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the {vld, ecc, req} beats still to appear, one per cycle.
  // An empty queue means the bus must be all zero and the block idle.
  logic [39:0] exp_q[$];
  bit          model_busy;
  int          iq_m, wib_m;
  bit          err_m;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

`ifdef JBI_L2_REQ_ECC_GEN_EN
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [6:0] e;
    int pos;
    e   = '0;
    pos = 1;
    for (int j = 0; j < 32; j++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      for (int k = 0; k < 6; k++) if (((pos >> k) & 1) == 1) e[k] = e[k] ^ d[j];
    end
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction
`endif

  task automatic push_packet();
    exp_q.push_back({1'b1, 7'd0, req_hdr[63:32]});
    exp_q.push_back({1'b0, 7'd0, req_hdr[31:0]});
    if (req_wr) begin
      for (int i = 0; i < 16; i++) begin
        logic [31:0] w;
        logic [6:0]  e;
        w = req_data[511-32*i -: 32];
`ifdef JBI_L2_REQ_ECC_GEN_EN
        e = ref_ecc(w);
`else
        e = req_ecc[111-7*i -: 7];
`endif
        exp_q.push_back({1'b0, e, w});
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_busy = 1'b0;
    iq_m       = IQ_DEPTH;
    wib_m      = WIB_DEPTH;
    err_m      = 1'b0;
  endtask

  // One clock cycle. It is called at a negedge after the inputs are set.
  // It checks the handshake, advances the model, and checks the outputs at
  // the next negedge.
  task automatic cycle(output bit acc);
    logic [39:0] exp_out;
    bit wdec;
    #1;
    acc = !model_busy && req_valid && (iq_m > 0) && (!req_wr || (wib_m > 0));
    if (req_valid) check("req_ready", 64'(req_ready), 64'(acc));
    if (acc) push_packet();
    if (sctag_jbi_iq_dequeue && !acc) begin
      if (iq_m == IQ_DEPTH) err_m = 1'b1; else iq_m++;
    end else if (!sctag_jbi_iq_dequeue && acc) iq_m--;
    wdec = acc && req_wr;
    if (sctag_jbi_wib_dequeue && !wdec) begin
      if (wib_m == WIB_DEPTH) err_m = 1'b1; else wib_m++;
    end else if (!sctag_jbi_wib_dequeue && wdec) wib_m--;
    @(posedge clk);
    @(negedge clk);
    model_busy = (exp_q.size() > 0);
    exp_out    = model_busy ? exp_q.pop_front() : 40'd0;
    check("beat", 64'({jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req}), 64'(exp_out));
    check("iq_credit", 64'(iq_credit), 64'(iq_m));
    check("wib_credit", 64'(wib_credit), 64'(wib_m));
    check("credit_err", 64'(credit_err), 64'(err_m));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fields(input bit wr, input logic [63:0] hdr, input logic [31:0] base);
    req_wr  = wr;
    req_hdr = hdr;
    for (int i = 0; i < 16; i++) begin
      req_data[511-32*i -: 32] = base + 32'(i);
      req_ecc[111-7*i -: 7]    = 7'(i);
    end
  endtask

  task automatic wait_idle();
    bit acc;
    int k;
    k = 0;
    while ((model_busy || exp_q.size() > 0) && k < 40) begin
      cycle(acc);
      k++;
    end
    if (model_busy || exp_q.size() > 0) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic drive_pkt(input bit wr, input logic [63:0] hdr, input logic [31:0] base);
    bit acc;
    int k;
    set_fields(wr, hdr, base);
    req_valid = 1'b1;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 64) begin
      cycle(acc);
      k++;
    end
    if (!acc) check("accept_timeout", 64'd1, 64'd0);
    req_valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst                   = 1'b1;
    req_valid             = 1'b1;
    req_wr                = 1'b0;
    sctag_jbi_iq_dequeue  = 1'b0;
    sctag_jbi_wib_dequeue = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_outputs", 64'({jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req}), 64'd0);
    check("rst_iq", 64'(iq_credit), 64'(IQ_DEPTH));
    check("rst_wib", 64'(wib_credit), 64'(WIB_DEPTH));
    check("rst_err", 64'(credit_err), 64'd0);
    req_valid = 1'b0;
    rst       = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [63:0] hdr;
    logic [31:0] base;
    int          iq_ret;
    int          wib_ret;
    int          exp_iq;
    int          exp_wib;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit acc;

    vecs[0] = '{1'b0, 64'hDEAD_BEEF_0123_4567, 32'h0,         0, 0, 15, 4, 1'b0};
    vecs[1] = '{1'b1, 64'h0000_1111_2222_3333, 32'h1000_0000, 0, 0, 14, 3, 1'b0};
    vecs[2] = '{1'b0, 64'hA5A5_A5A5_5A5A_5A5A, 32'h0,         2, 1, 15, 4, 1'b0};
    vecs[3] = '{1'b1, 64'h0123_4567_89AB_CDEF, 32'hCAFE_0000, 1, 0, 15, 3, 1'b0};
    vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFF0, 0, 0, 14, 2, 1'b0};
    vecs[5] = '{1'b1, 64'h8000_0000_0000_0001, 32'h7FFF_FFF8, 2, 2, 15, 3, 1'b0};
    vecs[6] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 32'h0,         1, 1, 15, 4, 1'b0};
    vecs[7] = '{1'b0, 64'h0F0F_0F0F_F0F0_F0F0, 32'h0,         2, 0, 16, 4, 1'b0};
    vecs[8] = '{1'b0, 64'h3C3C_3C3C_C3C3_C3C3, 32'h0,         2, 0, 16, 4, 1'b1};

    req_hdr  = '0;
    req_data = '0;
    req_ecc  = '0;
    @(negedge clk);
    do_reset();

    // Read timing with hand-computed beats.
    set_fields(1'b0, 64'hDEAD_BEEF_0123_4567, 32'h0);
    req_valid = 1'b1;
    cycle(acc);
    req_valid = 1'b0;
    check("rd_hdr_hi", 64'({jbi_sctag_req_vld, jbi_sctag_req}), 64'({1'b1, 32'hDEADBEEF}));
    check("rd_iq_dec", 64'(iq_credit), 64'd15);
    cycle(acc);
    check("rd_hdr_lo", 64'({jbi_sctag_req_vld, jbi_sctag_req}), 64'({1'b0, 32'h01234567}));
    cycle(acc);
    check("rd_idle", 64'({jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req}), 64'd0);

    // Table-driven packets with credit returns afterwards.
    do_reset();
    foreach (vecs[v]) begin
      int nret;
      drive_pkt(vecs[v].wr, vecs[v].hdr, vecs[v].base);
      nret = (vecs[v].iq_ret > vecs[v].wib_ret) ? vecs[v].iq_ret : vecs[v].wib_ret;
      for (int r = 0; r < nret; r++) begin
        sctag_jbi_iq_dequeue  = (r < vecs[v].iq_ret);
        sctag_jbi_wib_dequeue = (r < vecs[v].wib_ret);
        cycle(acc);
      end
      sctag_jbi_iq_dequeue  = 1'b0;
      sctag_jbi_wib_dequeue = 1'b0;
      check($sformatf("vec%0d_iq", v), 64'(iq_credit), 64'(vecs[v].exp_iq));
      check($sformatf("vec%0d_wib", v), 64'(wib_credit), 64'(vecs[v].exp_wib));
      check($sformatf("vec%0d_err", v), 64'(credit_err), 64'(vecs[v].exp_err));
    end

    // WIB exhaustion: a write is blocked, a read still goes, and a write
    // goes through once a WIB credit comes back.
    do_reset();
    for (int w = 0; w < 4; w++) drive_pkt(1'b1, 64'(w), 32'h2000_0000 + 32'(w << 4));
    check("wib_empty", 64'(wib_credit), 64'd0);
    set_fields(1'b1, 64'h5555_0000_0000_0005, 32'h3000_0000);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) cycle(acc);
    #1;
    check("wr_blocked", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    drive_pkt(1'b0, 64'h0000_0006_0000_0006, 32'h0);
    set_fields(1'b1, 64'h5555_0000_0000_0007, 32'h3100_0000);
    req_valid             = 1'b1;
    sctag_jbi_wib_dequeue = 1'b1;
    cycle(acc);
    sctag_jbi_wib_dequeue = 1'b0;
    #1;
    check("wr_after_return", 64'(req_ready), 64'd1);
    cycle(acc);
    req_valid = 1'b0;
    wait_idle();

    // Accept and IQ return in the same cycle leave the count unchanged.
    do_reset();
    drive_pkt(1'b0, 64'h1, 32'h0);
    set_fields(1'b0, 64'h2, 32'h0);
    req_valid            = 1'b1;
    sctag_jbi_iq_dequeue = 1'b1;
    cycle(acc);
    req_valid            = 1'b0;
    sctag_jbi_iq_dequeue = 1'b0;
    check("acc_deq_iq", 64'(iq_credit), 64'd15);
    wait_idle();

    // Reset in the middle of a write, while data beat 7 is on the bus.
    do_reset();
    set_fields(1'b1, 64'h7777_0000_0000_7777, 32'h4000_0000);
    req_valid = 1'b1;
    cycle(acc);
    req_valid = 1'b0;
    for (int k = 0; k < 9; k++) cycle(acc);
    check("mid_beat7", 64'(jbi_sctag_req), 64'h4000_0007);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    #1;
    check("mid_rst_outputs", 64'({jbi_sctag_req_vld, jbi_scbuf_ecc, jbi_sctag_req}), 64'd0);
    check("mid_rst_iq", 64'(iq_credit), 64'(IQ_DEPTH));
    check("mid_rst_wib", 64'(wib_credit), 64'(WIB_DEPTH));
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    model_reset();
    @(negedge clk);
    drive_pkt(1'b1, 64'h8888_0000_0000_8888, 32'h5000_0000);

`ifdef JBI_L2_REQ_ECC_GEN_EN
    // All-zero and all-one data words through the internal encoder.
    set_fields(1'b1, 64'h9999_0000_0000_9999, 32'h0);
    for (int i = 0; i < 16; i++) begin
      req_data[511-32*i -: 32] = (i % 2 == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
      req_ecc[111-7*i -: 7]    = 7'h55;
    end
    req_valid = 1'b1;
    cycle(acc);
    req_valid = 1'b0;
    wait_idle();
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_wr    = $urandom_range(0, 1);
      req_hdr   = {$urandom, $urandom};
      for (int i = 0; i < 16; i++) req_data[511-32*i -: 32] = $urandom;
      req_ecc   = {$urandom, $urandom, $urandom, $urandom};
      sctag_jbi_iq_dequeue  = (iq_m < IQ_DEPTH) && ($urandom_range(0, 2) == 0);
      sctag_jbi_wib_dequeue = (wib_m < WIB_DEPTH) && ($urandom_range(0, 5) == 0);
      cycle(acc);
    end
    req_valid             = 1'b0;
    sctag_jbi_iq_dequeue  = 1'b0;
    sctag_jbi_wib_dequeue = 1'b0;
    wait_idle();

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
